// File: rtl/if_pkg.sv
// Shared types and default sizing for the instruction fetch sequencer.
package if_pkg;

  localparam int unsigned AW_DEF       = 16;
  localparam int unsigned DW_DEF       = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam int unsigned PC_INC_DEF   = 1;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    HALT
  } state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_LOADER
  } owner_t;

endpackage

// File: rtl/if_port_arb.sv
// Memory port mux between fetch and loader, tracking who owns the single outstanding read.
module if_port_arb
  import if_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req_c,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_ack_c,
  output logic          fetch_rvalid_c,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic          mem_rvalid
);

  logic   out_q;
  owner_t owner_q;
  logic   fetch_out_c;
  logic   ld_out_c;

  assign fetch_out_c = out_q && (owner_q == OWN_FETCH);
  assign ld_out_c    = out_q && (owner_q == OWN_LOADER);

  // Loader wins whenever fetch has nothing in flight; no new request while anything is outstanding.
  assign ld_gnt         = !rst && ld_req && !fetch_out_c;
  assign mem_req        = !rst && !out_q && (ld_gnt || fetch_req_c);
  assign mem_addr       = ld_gnt ? ld_addr : fetch_addr;
  assign fetch_ack_c    = mem_req && mem_ack && !ld_gnt;
  assign fetch_rvalid_c = !rst && mem_rvalid && fetch_out_c;
  assign ld_rvalid      = !rst && mem_rvalid && ld_out_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= 1'b0;
      owner_q <= OWN_FETCH;
    end else if (mem_req && mem_ack) begin
      out_q   <= 1'b1;
      owner_q <= ld_gnt ? OWN_LOADER : OWN_FETCH;
    end else if (mem_rvalid) begin
      out_q <= 1'b0;
    end
  end

endmodule

// File: rtl/if_ctrl.sv
// Fetch sequencer: owns the PC, issues one read at a time, handles redirect, stall and halt.
module if_ctrl
  import if_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEF,
  parameter int unsigned   DW       = DW_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF),
  parameter logic [AW-1:0] PC_INC   = AW'(PC_INC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] new_pc,
  input  logic          br_ctrl,
  input  logic          hlt,
  input  logic          stall,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic          instr_valid,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic          halted
);

  state_t        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          discard_q, discard_d;
  logic          halt_q;
  logic          halt_any_c;
  logic          deliver_c;
  logic          valid_d;
  logic          fetch_req_c;
  logic          fetch_ack_c;
  logic          fetch_rvalid_c;

  assign halt_any_c  = hlt || halt_q;
  assign fetch_req_c = (state_q == FETCH) && !halt_any_c;

  if_port_arb #(.AW(AW)) u_arb (
    .clk            (clk),
    .rst            (rst),
    .fetch_req_c    (fetch_req_c),
    .fetch_addr     (fetch_pc_q),
    .fetch_ack_c    (fetch_ack_c),
    .fetch_rvalid_c (fetch_rvalid_c),
    .ld_req         (ld_req),
    .ld_addr        (ld_addr),
    .ld_gnt         (ld_gnt),
    .ld_rvalid      (ld_rvalid),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rvalid     (mem_rvalid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      discard_q   <= 1'b0;
      halt_q      <= 1'b0;
      instr       <= '0;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      discard_q   <= discard_d;
      halt_q      <= halt_q || hlt;
      instr_valid <= valid_d;
      halted      <= (state_d == HALT);
      if (deliver_c) begin
        instr <= mem_rdata;
        pc    <= fetch_pc_q;
      end
    end
  end

  // Next state, PC update and delivery decision.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    deliver_c  = 1'b0;
    valid_d    = 1'b0;
    case (state_q)
      FETCH: begin
        if (halt_any_c) begin
          state_d = HALT;
        end else if (fetch_ack_c) begin
          state_d   = WAIT;
          discard_d = br_ctrl;
        end
      end
      WAIT: begin
        if (fetch_rvalid_c) begin
          deliver_c = !discard_q && !br_ctrl;
          discard_d = 1'b0;
          if (halt_any_c)            state_d = HALT;
          else if (deliver_c && stall) state_d = HOLD;
          else                       state_d = FETCH;
        end else if (br_ctrl) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (br_ctrl || !stall) state_d = halt_any_c ? HALT : FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
    // Redirect overrides the sequential increment.
    if (deliver_c) fetch_pc_d = fetch_pc_q + PC_INC;
    if (br_ctrl)   fetch_pc_d = new_pc;
    valid_d = deliver_c || ((state_q == HOLD) && (state_d == HOLD));
  end

endmodule

// File: tb/tb_if_ctrl.sv
// Directed bench for if_ctrl with a variable-latency memory model (data = addr ^ 16'hA5A5).
module tb_if_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] new_pc = '0;
  logic        br_ctrl = 1'b0;
  logic        hlt = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        instr_valid;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        ld_req = 1'b0;
  logic [15:0] ld_addr = '0;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [15:0] paddr = '0;

  always #5 clk = ~clk;

  if_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .new_pc      (new_pc),
    .br_ctrl     (br_ctrl),
    .hlt         (hlt),
    .stall       (stall),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_gnt      (ld_gnt),
    .ld_rvalid   (ld_rvalid),
    .halted      (halted)
  );

  // Memory: accepts immediately, returns data lat cycles after the ack.
  assign mem_ack    = mem_req;
  assign mem_rvalid = pend && (cnt == 1);
  assign mem_rdata  = paddr ^ 16'hA5A5;

  always @(posedge clk) begin
    if (pend) begin
      if (cnt == 1) pend <= 1'b0;
      else          cnt  <= cnt - 1;
    end else if (mem_req && mem_ack) begin
      pend  <= 1'b1;
      cnt   <= lat;
      paddr <= mem_addr;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic restart;
    rst = 1'b1; br_ctrl = 1'b0; hlt = 1'b0; stall = 1'b0;
    ld_req = 1'b0; ld_addr = '0; new_pc = '0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ld_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({instr_valid, halted, mem_req, ld_gnt, ld_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000", {instr_valid, halted, mem_req, ld_gnt, ld_rvalid});
    end
    checks++;
    if ({pc, instr} !== 32'h0000_0000) begin
      errors++;
      $display("FAIL reset_pc_instr got %h exp 00000000", {pc, instr});
    end
    ld_req = 1'b0;
  endtask

  task automatic test_fetch;
    logic [15:0] epc [3];
    logic [15:0] edat [3];
    epc  = '{16'h0000, 16'h0001, 16'h0002};
    edat = '{16'hA5A5, 16'hA5A4, 16'hA5A7};
    lat = 1;
    restart;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL fetch_first_req got %b/%h exp 1/0000", mem_req, mem_addr);
    end
    for (int c = 1; c <= 6; c++) begin
      step;
      checks++;
      if (instr_valid !== 1'((c % 2) == 0)) begin
        errors++;
        $display("FAIL fetch_valid c=%0d got %b exp %b", c, instr_valid, 1'((c % 2) == 0));
      end
      if ((c % 2) == 0) begin
        checks++;
        if ({pc, instr} !== {epc[c/2-1], edat[c/2-1]}) begin
          errors++;
          $display("FAIL fetch_data c=%0d got %h/%h exp %h/%h", c, pc, instr, epc[c/2-1], edat[c/2-1]);
        end
      end
    end
  endtask

  task automatic test_stall;
    lat = 1;
    restart;
    repeat (7) step;
    stall = 1'b1;
    #1;
    for (int c = 8; c <= 11; c++) begin
      step;
      if (c == 11) begin
        stall = 1'b0;
        #1;
      end
      checks++;
      if ({instr_valid, pc, instr, mem_req} !== {1'b1, 16'h0003, 16'hA5A6, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold c=%0d got %b/%h/%h/%b exp 1/0003/a5a6/0", c, instr_valid, pc, instr, mem_req);
      end
    end
    step;
    checks++;
    if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 16'h0004}) begin
      errors++;
      $display("FAIL stall_resume got %b/%b/%h exp 0/1/0004", instr_valid, mem_req, mem_addr);
    end
    step;
    step;
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 16'h0004, 16'hA5A1}) begin
      errors++;
      $display("FAIL stall_next got %b/%h/%h exp 1/0004/a5a1", instr_valid, pc, instr);
    end
  endtask

  task automatic test_branch;
    lat = 1;
    restart;
    repeat (9) step;
    lat = 3;
    step;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0005}) begin
      errors++;
      $display("FAIL br_req5 got %b/%h exp 1/0005", mem_req, mem_addr);
    end
    step;
    br_ctrl = 1'b1;
    new_pc  = 16'h0040;
    #1;
    step;
    br_ctrl = 1'b0;
    #1;
    for (int c = 12; c <= 17; c++) begin
      if (c != 12) step;
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL br_discard c=%0d got %b exp 0", c, instr_valid);
      end
      if (c == 13) begin
        checks++;
        if (mem_req !== 1'b0) begin
          errors++;
          $display("FAIL br_no_req got %b exp 0", mem_req);
        end
      end
      if (c == 14) begin
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0040}) begin
          errors++;
          $display("FAIL br_target_req got %b/%h exp 1/0040", mem_req, mem_addr);
        end
      end
    end
    step;
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 16'h0040, 16'hA5E5}) begin
      errors++;
      $display("FAIL br_first got %b/%h/%h exp 1/0040/a5e5", instr_valid, pc, instr);
    end
    lat = 1;
  endtask

  task automatic test_wrap;
    lat = 1;
    restart;
    br_ctrl = 1'b1;
    new_pc  = 16'hFFFF;
    #1;
    step;
    br_ctrl = 1'b0;
    #1;
    step;
    checks++;
    if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 16'hFFFF}) begin
      errors++;
      $display("FAIL wrap_req got %b/%b/%h exp 0/1/ffff", instr_valid, mem_req, mem_addr);
    end
    step;
    step;
    checks++;
    if ({instr_valid, pc, instr, mem_addr} !== {1'b1, 16'hFFFF, 16'h5A5A, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_ffff got %b/%h/%h/%h exp 1/ffff/5a5a/0000", instr_valid, pc, instr, mem_addr);
    end
    step;
    step;
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 16'h0000, 16'hA5A5}) begin
      errors++;
      $display("FAIL wrap_0000 got %b/%h/%h exp 1/0000/a5a5", instr_valid, pc, instr);
    end
  endtask

  task automatic test_halt;
    lat = 1;
    restart;
    repeat (13) step;
    lat = 3;
    step;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0007}) begin
      errors++;
      $display("FAIL halt_req7 got %b/%h exp 1/0007", mem_req, mem_addr);
    end
    step;
    hlt = 1'b1;
    #1;
    step;
    hlt = 1'b0;
    #1;
    checks++;
    if ({halted, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL halt_wait got %b exp 00", {halted, mem_req});
    end
    step;
    step;
    checks++;
    if ({instr_valid, pc, instr, halted} !== {1'b1, 16'h0007, 16'hA5A2, 1'b1}) begin
      errors++;
      $display("FAIL halt_deliver got %b/%h/%h/%b exp 1/0007/a5a2/1", instr_valid, pc, instr, halted);
    end
    for (int c = 19; c <= 22; c++) begin
      step;
      checks++;
      if ({instr_valid, mem_req, halted} !== 3'b001) begin
        errors++;
        $display("FAIL halt_idle c=%0d got %b exp 001", c, {instr_valid, mem_req, halted});
      end
    end
    lat = 1;
    restart;
    checks++;
    if ({halted, mem_req, mem_addr, pc} !== {1'b0, 1'b1, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL halt_rst got %b/%b/%h/%h exp 0/1/0000/0000", halted, mem_req, mem_addr, pc);
    end
  endtask

  task automatic test_loader;
    lat = 3;
    restart;
    step;
    ld_req  = 1'b1;
    ld_addr = 16'h0100;
    #1;
    for (int c = 1; c <= 3; c++) begin
      if (c != 1) step;
      checks++;
      if ({ld_gnt, mem_req} !== 2'b00) begin
        errors++;
        $display("FAIL ld_blocked c=%0d got %b exp 00", c, {ld_gnt, mem_req});
      end
    end
    step;
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 16'h0000, 16'hA5A5}) begin
      errors++;
      $display("FAIL ld_fetch_done got %b/%h/%h exp 1/0000/a5a5", instr_valid, pc, instr);
    end
    checks++;
    if ({ld_gnt, mem_req, mem_addr} !== {1'b1, 1'b1, 16'h0100}) begin
      errors++;
      $display("FAIL ld_grant got %b/%b/%h exp 1/1/0100", ld_gnt, mem_req, mem_addr);
    end
    step;
    checks++;
    if ({instr_valid, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL ld_outstanding got %b exp 00", {instr_valid, mem_req});
    end
    step;
    step;
    ld_req = 1'b0;
    #1;
    checks++;
    if ({ld_rvalid, mem_rdata, instr_valid} !== {1'b1, 16'hA4A5, 1'b0}) begin
      errors++;
      $display("FAIL ld_data got %b/%h/%b exp 1/a4a5/0", ld_rvalid, mem_rdata, instr_valid);
    end
    step;
    checks++;
    if ({ld_rvalid, ld_gnt, mem_req, mem_addr} !== {1'b0, 1'b0, 1'b1, 16'h0001}) begin
      errors++;
      $display("FAIL ld_resume got %b/%b/%b/%h exp 0/0/1/0001", ld_rvalid, ld_gnt, mem_req, mem_addr);
    end
    repeat (4) step;
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 16'h0001, 16'hA5A4}) begin
      errors++;
      $display("FAIL ld_after got %b/%h/%h exp 1/0001/a5a4", instr_valid, pc, instr);
    end
    lat = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_fetch;
    test_stall;
    test_branch;
    test_wrap;
    test_halt;
    test_loader;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
